// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset CPU.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctl_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_A} src_a_t;
  typedef enum logic [1:0] {SRCB_FOUR, SRCB_B, SRCB_IMM} src_b_t;
  typedef enum logic [1:0] {WB_ALUOUT, WB_DATA, WB_ALU} wb_sel_t;

  // Per-cycle control word driven by the FSM into the datapath
  typedef struct packed {
    logic     mem_req;
    logic     mem_we;
    logic     addr_aluout;
    logic     ir_we;
    logic     oldpc_we;
    logic     pc_we;
    logic     pc_aluout;
    logic     ab_we;
    logic     aluout_we;
    logic     data_we;
    logic     rf_we;
    wb_sel_t  wb_sel;
    src_a_t   src_a;
    src_b_t   src_b;
    alu_ctl_t alu_ctl;
    imm_sel_t imm_sel;
    logic     retire;
    logic     trap;
  } ctrl_t;

  // Shared ALU; all arithmetic wraps modulo 2^XLEN
  function automatic logic [XLEN-1:0] alu(input alu_ctl_t ctl,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    case (ctl)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return XLEN'($signed(a) < $signed(b));
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle control: state register, opcode/funct decode and per-state enables.
module mc_control_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       a_eq_b,
  input  logic       mem_ready,
  output ctrl_t      ctrl_c
);

  state_t   state, state_nx;
  alu_ctl_t op_ctl;
  logic     op_legal;

  // funct3/funct7 to ALU control for R and I arithmetic
  always_comb begin
    op_ctl   = ALU_ADD;
    op_legal = 1'b1;
    case (funct3)
      F3_ADD:  op_ctl = (funct7b5 && (opcode == OP_R)) ? ALU_SUB : ALU_ADD;
      F3_AND:  op_ctl = ALU_AND;
      F3_OR:   op_ctl = ALU_OR;
      F3_XOR:  op_ctl = ALU_XOR;
      F3_SLT:  op_ctl = ALU_SLT;
      default: op_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next state and control word
  always_comb begin
    state_nx = state;
    ctrl_c   = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_we    = 1'b1;
          ctrl_c.oldpc_we = 1'b1;
          ctrl_c.pc_we    = 1'b1;
          state_nx        = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_c.ab_we     = 1'b1;
        ctrl_c.aluout_we = 1'b1;
        ctrl_c.src_a     = SRCA_OLDPC;
        ctrl_c.src_b     = SRCB_IMM;
        if (opcode == OP_JAL) ctrl_c.imm_sel = IMM_J;
        else                  ctrl_c.imm_sel = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl_c.aluout_we = 1'b1;
        ctrl_c.src_a     = SRCA_A;
        ctrl_c.src_b     = SRCB_IMM;
        if (opcode == OP_STORE) begin
          ctrl_c.imm_sel = IMM_S;
          state_nx       = S_MEMWR;
        end else begin
          ctrl_c.imm_sel = IMM_I;
          state_nx       = S_MEMRD;
        end
      end
      S_MEMRD: begin
        ctrl_c.mem_req     = 1'b1;
        ctrl_c.addr_aluout = 1'b1;
        if (mem_ready) begin
          ctrl_c.data_we = 1'b1;
          state_nx       = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl_c.rf_we  = 1'b1;
        ctrl_c.wb_sel = WB_DATA;
        ctrl_c.retire = 1'b1;
        state_nx      = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_c.mem_req     = 1'b1;
        ctrl_c.mem_we      = 1'b1;
        ctrl_c.addr_aluout = 1'b1;
        if (mem_ready) begin
          ctrl_c.retire = 1'b1;
          state_nx      = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        if (op_legal) begin
          ctrl_c.aluout_we = 1'b1;
          ctrl_c.src_a     = SRCA_A;
          ctrl_c.src_b     = (state == S_EXECR) ? SRCB_B : SRCB_IMM;
          ctrl_c.imm_sel   = IMM_I;
          ctrl_c.alu_ctl   = op_ctl;
          state_nx         = S_ALUWB;
        end else begin
          state_nx = S_TRAP;
        end
      end
      S_ALUWB: begin
        ctrl_c.rf_we  = 1'b1;
        ctrl_c.wb_sel = WB_ALUOUT;
        ctrl_c.retire = 1'b1;
        state_nx      = S_FETCH;
      end
      S_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          ctrl_c.retire    = 1'b1;
          ctrl_c.pc_aluout = 1'b1;
          ctrl_c.pc_we     = (funct3 == F3_BNE) ? !a_eq_b : a_eq_b;
          state_nx         = S_FETCH;
        end else begin
          state_nx = S_TRAP;
        end
      end
      S_JAL: begin
        ctrl_c.rf_we     = 1'b1;
        ctrl_c.wb_sel    = WB_ALU;
        ctrl_c.src_a     = SRCA_OLDPC;
        ctrl_c.src_b     = SRCB_FOUR;
        ctrl_c.pc_we     = 1'b1;
        ctrl_c.pc_aluout = 1'b1;
        ctrl_c.retire    = 1'b1;
        state_nx         = S_FETCH;
      end
      S_TRAP: begin
        ctrl_c.trap = 1'b1;
      end
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset CPU with a single shared ALU and one valid/ready memory port.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [CNT_W-1:0]  instret
);

  ctrl_t                   ctrl;
  logic [XLEN-1:0]         pc, oldpc, ir, a, b, aluout, data;
  logic [XLEN-1:0]         rf [0:31];
  logic [XLEN-1:0]         rs1_val, rs2_val, imm, src_a, src_b, alu_y, wb_data;
  logic [REG_AW-1:0]       rs1, rs2, rd;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  mc_control_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .opcode    (ir[6:0]),
    .funct3    (ir[14:12]),
    .funct7b5  (ir[30]),
    .a_eq_b    (a == b),
    .mem_ready (mem_ready),
    .ctrl_c    (ctrl)
  );

  // Register file read; x0 is hardwired to zero
  always_comb begin
    rs1_val = (rs1 == '0) ? '0 : rf[rs1];
    rs2_val = (rs2 == '0) ? '0 : rf[rs2];
  end

  // Immediate extension
  always_comb begin
    imm = '0;
    case (ctrl.imm_sel)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // ALU operand selection and the shared ALU
  always_comb begin
    src_a = pc;
    src_b = 32'd4;
    case (ctrl.src_a)
      SRCA_OLDPC: src_a = oldpc;
      SRCA_A:     src_a = a;
      default:    src_a = pc;
    endcase
    case (ctrl.src_b)
      SRCB_B:   src_b = b;
      SRCB_IMM: src_b = imm;
      default:  src_b = 32'd4;
    endcase
    alu_y = alu(ctrl.alu_ctl, src_a, src_b);
  end

  // Write-back source selection
  always_comb begin
    wb_data = aluout;
    case (ctrl.wb_sel)
      WB_DATA: wb_data = data;
      WB_ALU:  wb_data = alu_y;
      default: wb_data = aluout;
    endcase
  end

  // Memory port: request dropped during reset, payload zeroed when idle
  always_comb begin
    mem_req   = ctrl.mem_req & ~rst;
    mem_we    = mem_req & ctrl.mem_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) mem_addr = ctrl.addr_aluout ? ADDR_W'(aluout) : ADDR_W'(pc);
    if (mem_we)  mem_wdata = b;
  end

  // Architectural state with reset: PC, IR, halt flag, retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      instret <= '0;
    end else begin
      if (ctrl.pc_we)  pc <= ctrl.pc_aluout ? aluout : alu_y;
      if (ctrl.ir_we)  ir <= mem_rdata;
      if (ctrl.trap)   halted <= 1'b1;
      if (ctrl.retire) instret <= instret + CNT_W'(1);
    end
  end

  // Non-architectural datapath latches between cycles
  always_ff @(posedge clk) begin
    if (ctrl.oldpc_we)  oldpc  <= pc;
    if (ctrl.ab_we) begin
      a <= rs1_val;
      b <= rs2_val;
    end
    if (ctrl.aluout_we) aluout <= alu_y;
    if (ctrl.data_we)   data   <= mem_rdata;
  end

  // Register file write; x0 writes discarded, contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && ctrl.rf_we && (rd != '0)) rf[rd] <= wb_data;
  end

endmodule
